scan_sel_gen: RTL

Upstream sequencer for the 3-to-8 decoder. Produces the 3-bit select `a` and the enable `en` that drive the decoder, stepping round-robin through the channels selected by an 8-bit mask. Each channel is driven for a programmable dwell time. A blanking gap with `en` low separates channels, so the decoder output never shows two channels overlapping. Supports single-sweep and continuous modes for display and keypad scanning.

---
 rtl/scan_sel_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: round-robin select/enable sequencer for a 3-to-8 decoder.
// Walks the set bits of a latched channel mask. Each channel is preceded by an
// en-low blanking gap and is then driven for a programmable dwell time.
// Supports one-shot sweeps and continuous scanning.
module scan_sel_gen #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned BLANK   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         a,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic [7:0]         sweep_cnt
);

  localparam int unsigned BLANK_W = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q;
  logic [2:0]         a_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         sweep_q;
  logic [7:0]         mask_q;
  logic               mode_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [BLANK_W-1:0] blank_q;

  logic [2:0]         nxt_c;
  logic               wrap_c;
  logic [2:0]         low_c;

  // Next set bit strictly above cur, wrapping 7->0; returns cur if it is the only bit.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      idx = cur + 3'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [2:0] low_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Channel stepping: next channel and whether moving to it closes a sweep.
  always_comb begin
    nxt_c  = next_ch(mask_q, a_q);
    wrap_c = (nxt_c <= a_q);
    low_c  = low_ch(mask);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= 3'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sweep_q <= 8'd0;
      mask_q  <= 8'd0;
      mode_q  <= 1'b0;
      dwell_q <= DWELL_W'(1);
      cnt_q   <= '0;
      blank_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          en_q   <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start && !stop && (mask != 8'd0)) begin
            mask_q  <= mask;
            mode_q  <= mode;
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
            a_q     <= low_c;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            blank_q <= '0;
            if (BLANK == 0) begin
              state_q <= S_DRIVE;
              en_q    <= 1'b1;
            end else begin
              state_q <= S_BLANK;
            end
          end
        end

        S_BLANK: begin
          if (stop) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (blank_q == BLANK_LAST) begin
            state_q <= S_DRIVE;
            en_q    <= 1'b1;
            cnt_q   <= '0;
          end else begin
            blank_q <= blank_q + BLANK_W'(1);
          end
        end

        S_DRIVE: begin
          if (stop) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (cnt_q == dwell_q - DWELL_W'(1)) begin
            en_q    <= 1'b0;
            a_q     <= nxt_c;
            cnt_q   <= '0;
            blank_q <= '0;
            if (wrap_c) sweep_q <= sweep_q + 8'd1;
            if (wrap_c && !mode_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (BLANK == 0) begin
              state_q <= S_DRIVE;
              en_q    <= 1'b1;
            end else begin
              state_q <= S_BLANK;
            end
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a         = a_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sweep_cnt = sweep_q;

endmodule
